// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared depth default, strobe encodings and entry layout for the store buffer
package store_buffer_pkg;
  localparam int DEPTH_DEF = 4;
  localparam int ADDR_BITS = 32;
  localparam int DATA_BITS = 32;
  localparam int STRB_BITS = 4;
  localparam logic [STRB_BITS-1:0] STRB_W  = 4'hF;
  localparam logic [STRB_BITS-1:0] STRB_H0 = 4'h3;
  localparam logic [STRB_BITS-1:0] STRB_H1 = 4'hC;
  localparam logic [STRB_BITS-1:0] STRB_B0 = 4'h1;
  localparam logic [STRB_BITS-1:0] STRB_B1 = 4'h2;
  localparam logic [STRB_BITS-1:0] STRB_B2 = 4'h4;
  localparam logic [STRB_BITS-1:0] STRB_B3 = 4'h8;
  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
    logic [STRB_BITS-1:0] strb;
  } sb_entry_t;
endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: picks the youngest set bit of a per-slot match vector in a circular FIFO
//   match : per-slot match flags (already qualified by slot validity)
//   head  : slot index of the oldest entry
//   found : at least one slot matches
//   idx   : slot index of the youngest matching entry
module sb_fwd_match #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match,
  input  logic [PW-1:0]    head,
  output logic             found,
  output logic [PW-1:0]    idx
);
  logic [PW-1:0] j;
  // Walk from oldest to youngest; the last hit wins, so the youngest match is kept.
  always_comb begin
    found = 1'b0;
    idx = head;
    j = head;
    for (int i = 0; i < DEPTH; i++) begin
      j = head + PW'(i);
      if (match[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO with word-granular load forwarding and memory drain
//   clk, rst                         : clock, synchronous active-high reset
//   st_valid/st_addr/st_data/st_strb : store enqueue from MEM; st_full stalls upstream
//   ld_valid/ld_addr                 : load lookup; ld_hit/ld_data forward, ld_stall on partial overlap
//   mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb : head-entry write request to memory
//   empty                            : no stores held
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_strb,
  output logic        st_full,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic [31:0] ld_data,
  output logic        ld_stall,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        empty
);
  localparam int PW = $clog2(DEPTH);
  sb_entry_t        ent [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    head, tail, hit_idx;
  logic [PW:0]      count;
  logic             enq, deq, found;
  logic [DEPTH-1:0] match;
  assign empty     = count == '0;
  assign st_full   = count == (PW+1)'(DEPTH);
  assign mem_valid = !empty;
  assign mem_addr  = ent[head].addr;
  assign mem_wdata = ent[head].data;
  assign mem_wstrb = ent[head].strb;
  // Full is judged on registered count only, so a same-cycle dequeue never frees a slot for this store.
  assign enq = st_valid && !st_full;
  assign deq = mem_valid && mem_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (enq) begin
        vld[tail] <= 1'b1;
        tail <= tail + 1'b1;
      end
      if (deq) begin
        vld[head] <= 1'b0;
        head <= head + 1'b1;
      end
      count <= count + (PW+1)'(enq) - (PW+1)'(deq);
    end
  end
  always_ff @(posedge clk)
    if (enq) ent[tail] <= '{addr: st_addr, data: st_data, strb: st_strb};
  // Word match: byte offset bits are masked out of the comparison.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++)
      match[i] = vld[i] && (((ent[i].addr ^ ld_addr) & 32'hFFFF_FFFC) == 32'h0);
  end
  sb_fwd_match #(.DEPTH(DEPTH)) u_match (
    .match (match),
    .head  (head),
    .found (found),
    .idx   (hit_idx)
  );
  assign ld_hit   = ld_valid && found && ent[hit_idx].strb == STRB_W;
  assign ld_stall = ld_valid && found && ent[hit_idx].strb != STRB_W;
  assign ld_data  = ld_hit ? ent[hit_idx].data : 32'h0;
endmodule
